// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one multiplier bit per clock, signed via magnitude and sign fix-up
module seq_multiplier #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [size-1:0] src1_i,
  input  logic [size-1:0] src2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [size-1:0] hi_o,
  output logic [size-1:0] lo_o
);
  localparam int cw = $clog2(size);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [cw-1:0] cnt;
  logic [size-1:0] mcand, mag1, mag2;
  logic [2*size-1:0] prod, prod_nxt;
  logic [size:0] sum;
  logic neg, go, last;
  assign go = start_i && state != RUN;
  assign last = state == RUN && cnt == cw'(size - 1);
  assign busy_o = state == RUN;
  assign done_o = state == DONE;
  assign mag1 = (signed_i && src1_i[size-1]) ? -src1_i : src1_i;
  assign mag2 = (signed_i && src2_i[size-1]) ? -src2_i : src2_i;
  always_comb begin
    state_nxt = go ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  // Upper half accumulates while the multiplier drains out of the lower half.
  always_comb begin
    sum = {1'b0, prod[2*size-1:size]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {sum, prod[size-1:1]};
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
      neg   <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else if (go) begin
      cnt   <= '0;
      mcand <= mag1;
      prod  <= {{size{1'b0}}, mag2};
      neg   <= signed_i && (src1_i[size-1] ^ src2_i[size-1]);
    end else if (state == RUN) begin
      cnt  <= cnt + 1'b1;
      prod <= prod_nxt;
      if (last) {hi_o, lo_o} <= neg ? -prod_nxt : prod_nxt;
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of seq_multiplier latency, products, start/reset handling
module tb_seq_multiplier;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, signed_i = 1'b0;
  logic [31:0] src1_i = '0, src2_i = '0;
  logic busy_o, done_o;
  logic [31:0] hi_o, lo_o;
  int total = 0, bad = 0;
  bit hold_start = 1'b0;
  logic [63:0] exp_q[$];

  seq_multiplier #(.size(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
    .src1_i(src1_i), .src2_i(src2_i), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    return s ? 64'(longint'($signed(a)) * longint'($signed(b))) : {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    start_i = 1'b1; signed_i = s; src1_i = a; src2_i = b;
    exp_q.push_back(model(s, a, b));
  endtask

  task automatic run_to_done(input string tag, input int lat);
    int at = 0;
    for (int k = 1; k <= lat + 8; k++) begin
      @(negedge clk_i);
      if (k == 1) chk({tag, "_busy"}, 64'(busy_o), 64'd1);
      if (done_o) at = k;
      start_i = hold_start;
      if (at != 0) break;
    end
    chk({tag, "_lat"}, 64'(at), 64'(lat));
    chk({tag, "_q"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) chk({tag, "_prod"}, {hi_o, lo_o}, exp_q.pop_front());
  endtask

  task automatic do_op(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
    start_op(s, a, b);
    run_to_done(tag, 33);
  endtask

  initial begin
    int extra;
    #2 rst_i = 1'b0;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    do_op("u3x5", 1'b0, 32'd3, 32'd5);
    chk("u3x5_const", {hi_o, lo_o}, 64'h00000000_0000000F);
    @(negedge clk_i);
    chk("idle_done", 64'(done_o), 64'd0);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("idle_hold", {hi_o, lo_o}, 64'h00000000_0000000F);

    do_op("sm2x3", 1'b1, 32'hFFFFFFFE, 32'h00000003);
    chk("sm2x3_const", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);
    do_op("umax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("umax_const", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);
    do_op("sminsq", 1'b1, 32'h80000000, 32'h80000000);
    chk("sminsq_const", {hi_o, lo_o}, 64'h40000000_00000000);
    do_op("sminx1", 1'b1, 32'h80000000, 32'h00000001);
    chk("sminx1_const", {hi_o, lo_o}, 64'hFFFFFFFF_80000000);
    do_op("zero", 1'b0, 32'd0, 32'd123);
    do_op("szero", 1'b1, 32'hFFFFFFFF, 32'd0);
    for (int i = 0; i < 8; i++) do_op("rand", 1'($urandom), $urandom, $urandom);

    // start pulse during RUN must be ignored
    start_op(1'b0, 32'd7, 32'd6);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    @(negedge clk_i);
    start_i = 1'b1; src1_i = 32'd9; src2_i = 32'd9;
    run_to_done("ignore", 23);
    chk("ignore_42", {hi_o, lo_o}, 64'd42);
    extra = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) extra++;
    end
    chk("ignore_nodone", 64'(extra), 64'd0);

    // reset mid-RUN aborts
    start_op(1'b0, 32'd7, 32'd6);
    extra = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) extra++;
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    chk("abort_hilo", {hi_o, lo_o}, 64'd0);
    void'(exp_q.pop_front());
    repeat (20) begin
      @(negedge clk_i);
      if (done_o) extra++;
    end
    chk("abort_nodone", 64'(extra), 64'd0);
    rst_i = 1'b1;
    start_i = 1'b1; signed_i = 1'b0; src1_i = 32'd2; src2_i = 32'd2;
    exp_q.push_back(model(1'b0, 32'd2, 32'd2));
    run_to_done("postrst", 33);
    chk("postrst_4", {hi_o, lo_o}, 64'd4);

    // back-to-back with start held high
    hold_start = 1'b1;
    start_op(1'b0, 32'd1, 32'd1);
    @(negedge clk_i);
    src1_i = 32'd2; src2_i = 32'd3;
    run_to_done("b2b_a", 32);
    chk("b2b_a_1", {hi_o, lo_o}, 64'd1);
    exp_q.push_back(model(1'b0, 32'd2, 32'd3));
    hold_start = 1'b0;
    run_to_done("b2b_b", 33);
    chk("b2b_b_6", {hi_o, lo_o}, 64'd6);
    chk("final_q", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
